sine_period_meter: RTL and testbench
====================================

Name: sine_period_meter

Overview:
- Receive-side counterpart of the team's sine_a phase-accumulator generators.
- Consumes the free-running 12-bit unsigned (offset-binary, mid-scale 2048) sine sample stream and recovers its period in clocks and its per-period max/min amplitude.
- Used on the measurement side to verify or track the delta programmed into a generator.

Parameters:
- CW, 16, width of period counter and period output
- MID, 2048, mid-scale crossing level (unsigned 12-bit)
- HYST, 64, hysteresis half-band; rising event needs sample <= MID-HYST, then sample >= MID+HYST
- MAX_PERIOD, 2**CW-1, counter value at which measurement times out

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset (rst==0 resets)
- sind  input  12  unsigned sine sample, one new sample per clk
- period  output  CW  clocks between the last two rising events
- amp_max  output  12  largest sample within the last measured period
- amp_min  output  12  smallest sample within the last measured period
- valid  output  1  one-cycle pulse: period/amp_max/amp_min just updated
- lock  output  1  high while at least one valid period has been measured and no timeout has occurred since
- timeout  output  1  one-cycle pulse when the counter reaches MAX_PERIOD

Behaviour:
- Reset (rst==0, asynchronous): all outputs are 0, including period, amp_max, amp_min, valid, lock and timeout. State = INIT_LOW, cnt = 0, run_max = 0, run_min = 4095.
- All logic is single clock domain; sind is sampled combinationally at each rising clk edge; all outputs are registered.
- lo = (sind <= MID-HYST), hi = (sind >= MID+HYST), both unsigned compares.
- FSM states and transitions:
  - INIT_LOW: on lo, go to INIT_HIGH.
  - INIT_HIGH: on hi, this is the first rising event. Set cnt <= 1, run_max <= sind, run_min <= sind. Go to MEAS_LOW. No valid.
  - MEAS_LOW: cnt++. On lo, go to MEAS_HIGH.
  - MEAS_HIGH: cnt++. On hi, this is a rising event:
    - period <= cnt
    - amp_max <= run_max; amp_min <= run_min
    - valid <= 1; lock <= 1
    - cnt <= 1; run_max <= sind; run_min <= sind
    - go to MEAS_LOW
- Running max/min: in MEAS_LOW and MEAS_HIGH on non-event edges, run_max <= max(run_max, sind) and run_min <= min(run_min, sind). The reported window is therefore the samples from event t0 inclusive to event t1 exclusive.
- Latency: for events sampled on edges t0 and t1, period = t1-t0. period, amp_max, amp_min and valid are visible after edge t1. valid is high for exactly one cycle.
- Hysteresis: samples strictly inside (MID-HYST, MID+HYST) never cause a transition. Noise around mid-scale produces no events.
- Timeout: in MEAS_LOW or MEAS_HIGH, if cnt == MAX_PERIOD and no event occurs on that edge:
  - state <= INIT_LOW, cnt <= 0
  - lock <= 0, timeout pulses 1 for one cycle
  - period, amp_max and amp_min hold their last values
- Timeout vs event on the same edge: the event wins; no timeout.
- cnt never wraps: it saturates via the timeout path.
- valid and timeout are never high in the same cycle.
- Reset mid-measurement: immediate return to the reset values. The first valid after reset requires two new rising events.
- Width rules: period is zero-extended from cnt. amp values are raw 12-bit samples with no sign interpretation.

Test Plan:
- Square stimulus, sind = 0 for 10 clk then 4095 for 10 clk, repeated 5 times -> first valid at the 2nd rising edge of the stimulus, then period = 20, amp_max = 4095, amp_min = 0 on every valid; lock = 1 from the first valid.
- sind alternating 2048+63 / 2048-63 for 1000 clk after reset -> no valid, lock = 0, timeout = 0 (hysteresis rejects).
- Lock with period 20, then hold sind = 4095 -> timeout pulse exactly when cnt reaches 65535 (MAX_PERIOD after the last event), lock falls to 0, period stays 20; resumed square wave gives the next valid after two new events.
- Two sine_a instances with delta 16 and delta 32 driven into two meters -> the reported periods are in a 2:1 ratio ±1, and amp_max/amp_min match the generator extremes.
- Assert rst = 0 for 3 clk in the middle of a period while locked -> all outputs 0 during reset; after release, no valid until two new rising events.
- Rising event coinciding with cnt == MAX_PERIOD (period = 65535 stimulus) -> valid with period = 65535; no timeout pulse.

Source files
------------

// File: rtl/sine_period_meter.sv
// sine_period_meter
//   Measures a free-running 12-bit offset-binary sine stream (mid-scale MID).
//   Each rising crossing, with hysteresis, is one event. The block reports:
//   - the number of clocks between the last two events
//   - the largest and smallest sample seen over that window
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   sind     12-bit unsigned sample, one per clock
//   period   clocks between the last two rising events (zero-extended count)
//   amp_max  largest sample of the last measured period
//   amp_min  smallest sample of the last measured period
//   valid    one-cycle pulse when period/amp_max/amp_min update
//   lock     high from the first measured period until a timeout
//   timeout  one-cycle pulse when the counter reaches MAX_PERIOD
module sine_period_meter #(
   parameter int CW         = 16,
   parameter int MID        = 2048,
   parameter int HYST       = 64,
   parameter int MAX_PERIOD = 2**CW-1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [11:0]   sind,
   output logic [CW-1:0] period,
   output logic [11:0]   amp_max,
   output logic [11:0]   amp_min,
   output logic          valid,
   output logic          lock,
   output logic          timeout
);

   localparam logic [11:0]   LO_TH   = 12'(MID - HYST);
   localparam logic [11:0]   HI_TH   = 12'(MID + HYST);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PERIOD);

   typedef enum logic [1:0] {
      INIT_LOW,
      INIT_HIGH,
      MEAS_LOW,
      MEAS_HIGH
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [11:0]     run_max, run_min;

   logic lo, hi, meas, first_evt, rise_evt, tmo_evt;

   function automatic logic [11:0] umax(input logic [11:0] a, input logic [11:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [11:0] umin(input logic [11:0] a, input logic [11:0] b);
      return (a < b) ? a : b;
   endfunction

   // Event decode and next-state logic
   always_comb begin
      lo        = (sind <= LO_TH);
      hi        = (sind >= HI_TH);
      meas      = (state == MEAS_LOW) || (state == MEAS_HIGH);
      first_evt = (state == INIT_HIGH) && hi;
      rise_evt  = (state == MEAS_HIGH) && hi;
      // A rising event on the saturation edge still counts as a period.
      tmo_evt   = meas && !rise_evt && (cnt == CNT_MAX);

      state_nxt = state;
      unique case (state)
         INIT_LOW:  if (lo) state_nxt = INIT_HIGH;
         INIT_HIGH: if (hi) state_nxt = MEAS_LOW;
         MEAS_LOW: begin
            if (tmo_evt)  state_nxt = INIT_LOW;
            else if (lo)  state_nxt = MEAS_HIGH;
         end
         MEAS_HIGH: begin
            if (rise_evt)     state_nxt = MEAS_LOW;
            else if (tmo_evt) state_nxt = INIT_LOW;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= INIT_LOW;
      else      state <= state_nxt;
   end

   // Counter, running extremes and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         run_max <= 12'd0;
         run_min <= 12'd4095;
         period  <= '0;
         amp_max <= 12'd0;
         amp_min <= 12'd0;
         valid   <= 1'b0;
         lock    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         valid   <= 1'b0;
         timeout <= 1'b0;

         // The event sample opens the next window, so it seeds the extremes.
         if (first_evt || rise_evt) begin
            cnt     <= CW'(1);
            run_max <= sind;
            run_min <= sind;
         end else if (tmo_evt) begin
            cnt <= '0;
         end else if (meas) begin
            cnt     <= cnt + CW'(1);
            run_max <= umax(run_max, sind);
            run_min <= umin(run_min, sind);
         end

         if (rise_evt) begin
            period  <= cnt;
            amp_max <= run_max;
            amp_min <= run_min;
            valid   <= 1'b1;
            lock    <= 1'b1;
         end

         if (tmo_evt) begin
            lock    <= 1'b0;
            timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sine_period_meter.sv
module tb_sine_period_meter;

   // Narrow counter keeps the timeout scenarios short: MAX_PERIOD = 1023.
   localparam int TB_CW  = 10;
   localparam int TB_MAX = 2**TB_CW - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [11:0]      sind = 12'd0;
   logic [TB_CW-1:0] period;
   logic [11:0]      amp_max, amp_min;
   logic             valid, lock, timeout;

   int total = 0;
   int bad   = 0;

   sine_period_meter #(.CW(TB_CW)) dut (
      .clk     (clk),
      .rst     (rst),
      .sind    (sind),
      .period  (period),
      .amp_max (amp_max),
      .amp_min (amp_min),
      .valid   (valid),
      .lock    (lock),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic [11:0] v);
      sind = v;
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_period"},  period,  0);
      check({tag, "_amp_max"}, amp_max, 0);
      check({tag, "_amp_min"}, amp_min, 0);
      check({tag, "_valid"},   valid,   0);
      check({tag, "_lock"},    lock,    0);
      check({tag, "_timeout"}, timeout, 0);
   endtask

   task automatic do_reset();
      rst  = 1'b0;
      sind = 12'd0;
      #1;
      check_zero("rst");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   function automatic logic [11:0] sq(input int i);
      return (((i / 10) % 2) != 0) ? 12'd4095 : 12'd0;
   endfunction

   logic [11:0] pat16 [16] = '{12'd2112, 12'd3500, 12'd2600, 12'd2050, 12'd1500, 12'd1984,
                               12'd150,  12'd700,  12'd1200, 12'd1950, 12'd2000, 12'd2090,
                               12'd2100, 12'd2110, 12'd2111, 12'd2111};
   logic [11:0] pat8  [8]  = '{12'd4000, 12'd3000, 12'd10, 12'd20, 12'd30, 12'd40, 12'd50, 12'd2000};

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nv, nt, nl, vat, tat;
      logic lock_before;

      // Square wave, 10 low / 10 high: events at samples 10, 30, 50, ...
      do_reset();
      for (int i = 0; i < 100; i++) begin
         step(sq(i));
         check("sq_valid", valid, (i >= 30 && ((i - 10) % 20) == 0) ? 1 : 0);
         check("sq_lock", lock, (i >= 30) ? 1 : 0);
         if (valid) begin
            check("sq_period",  period,  20);
            check("sq_amp_max", amp_max, 4095);
            check("sq_amp_min", amp_min, 0);
         end
      end

      // Noise just inside the hysteresis band never produces an event.
      do_reset();
      nv = 0; nt = 0; nl = 0;
      for (int i = 0; i < 1000; i++) begin
         step(((i % 2) != 0) ? 12'd2111 : 12'd1985);
         nv += int'(valid);
         nt += int'(timeout);
         nl += int'(lock);
      end
      check("hyst_valid_cnt", nv, 0);
      check("hyst_timeout_cnt", nt, 0);
      check("hyst_lock_cnt", nl, 0);

      // Lock on period 20, then hold high: timeout MAX_PERIOD edges after sample 30.
      do_reset();
      nv = 0; nt = 0; vat = -1; tat = -1; lock_before = 1'b0;
      for (int i = 0; i < 1061; i++) begin
         step((i < 30) ? sq(i) : 12'd4095);
         if (valid)   begin nv++; vat = i; end
         if (timeout) begin nt++; tat = i; end
         check("to_no_overlap", valid & timeout, 0);
         if (i == 30 + TB_MAX - 1) lock_before = lock;
      end
      check("to_valid_cnt", nv, 1);
      check("to_valid_at", vat, 30);
      check("to_pulse_cnt", nt, 1);
      check("to_pulse_at", tat, 30 + TB_MAX);
      check("to_lock_before", lock_before, 1);
      check("to_lock_after", lock, 0);
      check("to_period_hold", period, 20);
      check("to_amp_max_hold", amp_max, 4095);
      check("to_amp_min_hold", amp_min, 0);
      nv = 0; vat = -1;
      for (int j = 0; j < 31; j++) begin
         step(sq(j));
         if (valid) begin nv++; vat = j; end
      end
      check("resume_valid_cnt", nv, 1);
      check("resume_valid_at", vat, 30);
      check("resume_period", period, 20);
      check("resume_lock", lock, 1);

      // Rising event exactly when the counter saturates: event wins.
      do_reset();
      nv = 0; nt = 0; vat = -1;
      for (int i = 0; i < 1041; i++) begin
         if (i < 10)        step(12'd0);
         else if (i <= 519) step(12'd4095);
         else if (i <= 1032) step(12'd0);
         else               step(12'd4095);
         if (valid) begin nv++; vat = i; end
         nt += int'(timeout);
      end
      check("sat_valid_cnt", nv, 1);
      check("sat_valid_at", vat, 10 + TB_MAX);
      check("sat_period", period, TB_MAX);
      check("sat_timeout_cnt", nt, 0);
      check("sat_lock", lock, 1);
      check("sat_amp_max", amp_max, 4095);
      check("sat_amp_min", amp_min, 0);

      // Shaped waveform, period 16, exact threshold values included.
      do_reset();
      step(12'd0);
      nv = 0;
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < 16; k++) begin
            step(pat16[k]);
            if (valid) begin
               nv++;
               check("p16_period",  period,  16);
               check("p16_amp_max", amp_max, 3500);
               check("p16_amp_min", amp_min, 150);
            end
         end
      check("p16_valid_cnt", nv, 2);

      // Shaped waveform, period 8 (half of the previous one).
      do_reset();
      step(12'd0);
      nv = 0;
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < 8; k++) begin
            step(pat8[k]);
            if (valid) begin
               nv++;
               check("p8_period",  period,  8);
               check("p8_amp_max", amp_max, 4000);
               check("p8_amp_min", amp_min, 10);
            end
         end
      check("p8_valid_cnt", nv, 2);

      // Reset in the middle of a locked period.
      do_reset();
      for (int i = 0; i < 45; i++) step(sq(i));
      check("mid_lock_pre", lock, 1);
      rst = 1'b0;
      #1;
      check_zero("mid_async");
      for (int i = 45; i < 48; i++) begin
         step(sq(i));
         check_zero("mid_hold");
      end
      rst = 1'b1;
      nv = 0; vat = -1;
      for (int i = 48; i < 76; i++) begin
         step(sq(i));
         if (valid) begin nv++; vat = i; end
      end
      check("mid_valid_cnt", nv, 1);
      check("mid_valid_at", vat, 70);
      check("mid_period", period, 20);
      check("mid_lock_post", lock, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
